// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I instruction fields into 32-bit words and
// streams them as sequential word writes into instruction memory, starting
// at a base address latched when a load starts. A single output register
// sits between the field-bundle handshake and the memory-write handshake.
module instruction_encoder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_format,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [31:0]            in_imm,
  input  logic                   in_last,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_data,
  output logic [3:0]             mem_byte_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Standard RV32I bit placement. Immediate bits that a format cannot
  // represent (imm[0] for B/J, upper bits for I/S) are simply dropped, as
  // are register/funct fields the format does not carry.
  function automatic logic [31:0] pack_word(
    input logic [2:0]         fmt,
    input logic [6:0]         opc,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [31:0] imm
  );
    logic [31:0] word;
    word = '0;
    case (fmt)
      FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: word = {imm[11:0], rs1, f3, rd, opc};
      FMT_S: word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_U: word = {imm[31:12], rd, opc};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: word = '0;
    endcase
    return word;
  endfunction

  // Formats 6 and 7 have no encoding.
  function automatic logic fmt_legal(input logic [2:0] fmt);
    return (fmt <= FMT_J);
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [31:0]              r_ptr;
  logic                     r_error;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_mem_vld_p1;
  logic [31:0]              r_mem_addr_p1;
  logic [31:0]              r_mem_data_p1;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_legal;
  logic                     w_load;
  logic                     w_xfer;
  logic                     w_start_ok;
  logic signed [31:0]       w_imm;
  logic [31:0]              w_word_p0;

  assign w_imm      = in_imm;
  assign w_xfer     = r_mem_vld_p1 && mem_ready;
  // The output register is single-entry: it can take a new word when empty
  // or when its current word leaves on this same edge.
  assign w_in_ready = (r_state == S_RUN) && (!r_mem_vld_p1 || mem_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_legal    = fmt_legal(in_format);
  assign w_load     = w_accept && w_legal;
  assign w_start_ok = (r_state == S_IDLE) && start;

  // ---- stage p0: field bundle packed combinationally ----
  assign w_word_p0  = pack_word(in_format, in_opcode, in_funct3, in_funct7,
                                in_rd, in_rs1, in_rs2, w_imm);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic framing one program load.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // An illegal bundle marked last still ends the load.
        if (w_accept && in_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_mem_vld_p1 || w_xfer) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write pointer, sticky error flag and completed-write counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_error <= 1'b0;
      r_count <= '0;
    end else if (w_start_ok) begin
      r_ptr   <= base_addr & 32'hFFFF_FFFC;
      r_error <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_load) r_ptr <= r_ptr + 32'd4;
      if (w_accept && !w_legal) r_error <= 1'b1;
      if (w_xfer) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  // ---- stage p1: output register toward instruction memory ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_vld_p1  <= 1'b0;
      r_mem_addr_p1 <= '0;
      r_mem_data_p1 <= '0;
    end else if (w_load) begin
      r_mem_vld_p1  <= 1'b1;
      r_mem_addr_p1 <= r_ptr;
      r_mem_data_p1 <= w_word_p0;
    end else if (w_xfer) begin
      r_mem_vld_p1  <= 1'b0;
    end
  end

  assign in_ready        = w_in_ready;
  assign mem_valid       = r_mem_vld_p1;
  assign mem_address     = r_mem_addr_p1;
  assign mem_data        = r_mem_data_p1;
  assign mem_byte_enable = 4'hF;
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);
  assign error           = r_error;
  assign word_count      = r_count;

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the core's instruction decoder: a streaming encoder/loader that takes RV32I instruction fields plus a format selector and packs them into 32-bit instruction words.
- Writes the packed words sequentially into instruction memory, starting at a programmable base address.
- Used by the boot/test loader path to fill instruction memory before the core is released.
- Single output register with valid/ready on both sides; a small FSM frames each program load.

Parameters:
- COUNT_WIDTH, 16, width of the words-written counter; it wraps at 2^COUNT_WIDTH.

Ports:
- clock  in  1  Single clock. All state is updated on the rising edge.
- reset_n  in  1  Reset is asynchronous and active-low.
- start  in  1  Pulse that begins a load. Ignored unless in IDLE.
- base_addr  in  32  First write address, latched on start. Bits [1:0] are forced to 0.
- in_valid  in  1  Field bundle is valid.
- in_ready  out  1  Encoder can accept a field bundle.
- in_format  in  3  Format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J. Values 6 and 7 are illegal.
- in_opcode  in  7  Opcode field.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_rd, in_rs1, in_rs2  in  5 each  Register indices.
- in_imm  in  32  Sign-extended immediate, as the decoder would reconstruct it.
- in_last  in  1  Marks the final bundle of the load.
- mem_valid  out  1  Write request is pending.
- mem_ready  in  1  Memory accepts the write request.
- mem_address  out  32  Word-aligned write address.
- mem_data  out  32  Packed instruction word.
- mem_byte_enable  out  4  Constant 4'hF.
- busy  out  1  High in every state except IDLE.
- done  out  1  One-cycle pulse at the end of a load.
- error  out  1  Sticky flag: an illegal format was received. Cleared on start.
- word_count  out  COUNT_WIDTH  Number of words written since the last start.

Behaviour:
- Reset (asynchronous, reset_n=0) forces all outputs to 0: in_ready, mem_valid, mem_address, mem_data, busy, done, error, word_count. FSM returns to IDLE and the internal address pointer is 0. A write in flight is abandoned with no completion.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - On start: ptr <= {base_addr[31:2],2'b00}, word_count <= 0, error <= 0, go to RUN.
- RUN:
  - in_ready = !mem_valid || mem_ready (single-entry output register, pass-through on the same cycle).
  - Accept = in_valid && in_ready.
  - On accept with a legal format: mem_data <= packed word, mem_address <= ptr, mem_valid <= 1, ptr <= ptr+4 (wraps modulo 2^32).
  - On accept with an illegal format (6/7): bundle is dropped, error <= 1, ptr is unchanged, no write is issued.
  - An accepted bundle with in_last=1 moves the FSM to DRAIN, whether or not the bundle was legal.
- Packing (standard RV32I layout):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Unused fields and imm bits are ignored (for example imm[0] for B/J, funct7 outside R).
- Output handshake:
  - A transfer occurs when mem_valid && mem_ready. On a transfer, word_count increments (wraps).
  - mem_valid clears on a transfer unless a new word loads in the same cycle.
  - mem_address and mem_data are held stable while mem_valid && !mem_ready.
- DRAIN: in_ready=0. When mem_valid is 0, or a transfer completes this cycle, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the IDLE cycle that follows.
- Simultaneous events:
  - start while busy is ignored.
  - in_valid while in IDLE/DRAIN/DONE is not accepted and has no effect.
  - Output transfer and input accept in the same cycle: the register reloads and word_count increments by 1.
- Latency: a bundle accepted on cycle N is presented on mem_* in cycle N+1.
- Throughput: one word per cycle with mem_ready held high.

Test Plan:
- Reset values, then start with base_addr=0x00001003 and four bundles, mem_ready=1:
  - I addi x1,x0,5 -> 0x00500093 @0x1000.
  - R add x3,x1,x2 -> 0x002081B3 @0x1004.
  - S sw x2,8(x1) -> 0x0020A423 @0x1008.
  - U lui x5,0x12345 (last) -> 0x123452B7 @0x100C.
  - Then done pulses once and word_count=4.
- B beq x0,x0,imm=-4 -> 0xFE000EE3; J jal x1,imm=8 -> 0x008000EF. Checks that imm[0] is ignored when imm=0xFFFFFFFD.
- Backpressure: hold mem_ready=0 for 5 cycles with a word pending -> in_ready=0, mem_data/mem_address stable. Release -> one transfer per cycle at full throughput.
- Illegal format 7 mid-stream -> error=1, no write, next legal word takes the skipped address. A following start clears error.
- Ignored events: start asserted during RUN is ignored. in_valid in IDLE is not accepted.
- Reset mid-load: assert reset_n=0 while mem_valid=1 -> outputs clear asynchronously without waiting for a clock edge. After release, a new start reloads base_addr.
